// File: rtl/wb_trace_monitor_pkg.sv
// Shared register indices, halt FSM encoding and trace entry layout for the writeback monitor.
// Constants only: no latency, no flow control.
package wb_trace_monitor_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_V1   = 5'd3;
  localparam logic [4:0] REG_S0   = 5'd16;
  localparam logic [4:0] REG_S1   = 5'd17;

  localparam int TRACE_W = 37;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SETTLE = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  typedef struct packed {
    logic [4:0]  reg_idx;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered pop data; push/pop to Count takes 1 cycle.
// A push while full is accepted only if a pop frees a slot in the same cycle, else it is dropped and overflow pulses.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  // When full, the slot being read this edge is the one being written, so the read sees the old entry.
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      pop_valid <= pop_ok;
      count     <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_trace_monitor.sv
// Logs writebacks to tracked registers into a trace FIFO and detects a parked-PC halt; capture to Empty=0 and RdEn to RdValid are 1 cycle.
// No backpressure on the pipeline: captures arriving while the FIFO is full are dropped and flagged in sticky Overflow.
module wb_trace_monitor
  import wb_trace_monitor_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8,
  parameter int TRACK_A     = 2,
  parameter int TRACK_B     = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   WBregwrite,
  input  logic [4:0]             WriteRegister,
  input  logic [31:0]            WriteData,
  input  logic [31:0]            PCResult,
  input  logic                   RdEn,
  output logic                   RdValid,
  output logic [4:0]             RdReg,
  output logic [31:0]            RdData,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Empty,
  output logic                   Full,
  output logic                   Overflow,
  output logic                   Halted,
  output logic [31:0]            HaltPC,
  output logic [31:0]            WriteCount
);

  localparam int CNT_W = $clog2(HALT_CYCLES) + 1;

  logic         capture;
  logic         drop;
  trace_entry_t push_entry;
  trace_entry_t pop_entry;

  assign capture = WBregwrite && (WriteRegister != REG_ZERO) &&
                   ((WriteRegister == 5'(TRACK_A)) || (WriteRegister == 5'(TRACK_B)));
  assign push_entry = '{reg_idx: WriteRegister, data: WriteData};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk       (Clk),
    .reset     (Reset),
    .push      (capture),
    .push_data (push_entry),
    .pop       (RdEn),
    .pop_valid (RdValid),
    .pop_data  (pop_entry),
    .count     (Count),
    .full      (Full),
    .empty     (Empty),
    .overflow  (drop)
  );

  assign RdReg  = pop_entry.reg_idx;
  assign RdData = pop_entry.data;

  halt_state_t      halt_state, halt_state_nxt;
  logic [31:0]      anchor, anchor_nxt;
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
  logic             in_window;
  logic             halt_hit;

  // Two-word window tolerates a self-jump whose fall-through fetch gets squashed, and stalls.
  assign in_window = (PCResult == anchor) || (PCResult == anchor + 32'd4);

  always_comb begin
    halt_state_nxt = halt_state;
    anchor_nxt     = anchor;
    run_cnt_nxt    = run_cnt;
    halt_hit       = 1'b0;
    case (halt_state)
      RUN: begin
        if (in_window) begin
          halt_state_nxt = SETTLE;
          run_cnt_nxt    = CNT_W'(1);
        end else begin
          anchor_nxt = PCResult;
        end
      end
      SETTLE: begin
        if (!in_window) begin
          halt_state_nxt = RUN;
          anchor_nxt     = PCResult;
          run_cnt_nxt    = '0;
        end else if (run_cnt == CNT_W'(HALT_CYCLES - 1)) begin
          halt_state_nxt = HALTED;
          halt_hit       = 1'b1;
        end else begin
          run_cnt_nxt = run_cnt + 1'b1;
        end
      end
      HALTED: halt_state_nxt = HALTED;
      default: halt_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      halt_state <= RUN;
      anchor     <= '0;
      run_cnt    <= '0;
      Halted     <= 1'b0;
      HaltPC     <= '0;
      Overflow   <= 1'b0;
      WriteCount <= '0;
    end else begin
      halt_state <= halt_state_nxt;
      anchor     <= anchor_nxt;
      run_cnt    <= run_cnt_nxt;
      if (halt_hit) begin
        Halted <= 1'b1;
        HaltPC <= anchor;
      end
      if (drop)    Overflow   <= 1'b1;
      if (capture) WriteCount <= WriteCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed-vector bench for wb_trace_monitor: capture filter, FIFO full/overflow/simultaneous cases,
// halt detection on parked PCs, and mid-operation reset.
module tb_wb_trace_monitor;
  import wb_trace_monitor_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        WBregwrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] PCResult;
  logic        RdEn;
  logic        RdValid;
  logic [4:0]  RdReg;
  logic [31:0] RdData;
  logic [4:0]  Count;
  logic        Empty;
  logic        Full;
  logic        Overflow;
  logic        Halted;
  logic [31:0] HaltPC;
  logic [31:0] WriteCount;

  int n_vec  = 0;
  int n_miss = 0;

  wb_trace_monitor #(
    .DEPTH(16), .HALT_CYCLES(8), .TRACK_A(2), .TRACK_B(3)
  ) dut (
    .Clk(Clk), .Reset(Reset), .WBregwrite(WBregwrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .PCResult(PCResult), .RdEn(RdEn), .RdValid(RdValid),
    .RdReg(RdReg), .RdData(RdData), .Count(Count), .Empty(Empty), .Full(Full),
    .Overflow(Overflow), .Halted(Halted), .HaltPC(HaltPC), .WriteCount(WriteCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input logic we, input logic [4:0] r, input logic [31:0] d, input logic rd);
    WBregwrite = we; WriteRegister = r; WriteData = d; RdEn = rd;
    step();
    WBregwrite = 1'b0; RdEn = 1'b0;
  endtask

  task automatic pc_tick(input logic [31:0] pc);
    PCResult = pc;
    step();
  endtask

  task automatic do_reset();
    Reset = 1'b1; WBregwrite = 1'b0; WriteRegister = '0; WriteData = '0; RdEn = 1'b0;
    PCResult = 32'h1000;
    step(); step();
    Reset = 1'b0;
  endtask

  task automatic pop_exp(input logic [4:0] r, input logic [31:0] d);
    RdEn = 1'b1;
    step();
    RdEn = 1'b0;
    chk("pop_vld", 32'(RdValid), 32'd1);
    chk("pop_reg", 32'(RdReg), 32'(r));
    chk("pop_dat", RdData, d);
    step();
    chk("pop_vld_drop", 32'(RdValid), 32'd0);
    chk("pop_dat_hold", RdData, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_full", 32'(Full), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_haltpc", HaltPC, 32'd0);
    chk("rst_wcnt", WriteCount, 32'd0);
    chk("rst_rdvld", 32'(RdValid), 32'd0);
    chk("rst_rdreg", 32'(RdReg), 32'd0);
    chk("rst_rddat", RdData, 32'd0);

    // Capture filter: only regs 2 and 3 with write enable
    tick(1'b1, 5'd2, 32'h11, 1'b0);
    chk("cap_empty_lat", 32'(Empty), 32'd0);
    tick(1'b1, 5'd8, 32'h22, 1'b0);
    tick(1'b1, 5'd3, 32'h33, 1'b0);
    tick(1'b1, 5'd0, 32'h44, 1'b0);
    tick(1'b0, 5'd2, 32'h55, 1'b0);
    chk("flt_count", 32'(Count), 32'd2);
    chk("flt_wcnt", WriteCount, 32'd2);
    pop_exp(5'd2, 32'h11);
    pop_exp(5'd3, 32'h33);
    chk("flt_empty", 32'(Empty), 32'd1);
    tick(1'b0, 5'd0, 32'h0, 1'b1);
    chk("empty_pop_vld", 32'(RdValid), 32'd0);
    chk("empty_pop_hold", RdData, 32'h33);

    // Overflow: 17 captures into 16 slots
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      tick(1'b1, 5'd2, 32'(i), 1'b0);
      if (i == 16) begin
        chk("fill_full", 32'(Full), 32'd1);
        chk("fill_noovf", 32'(Overflow), 32'd0);
      end
    end
    chk("ovf_flag", 32'(Overflow), 32'd1);
    chk("ovf_count", 32'(Count), 32'd16);
    chk("ovf_wcnt", WriteCount, 32'd17);
    for (int i = 1; i <= 16; i++) pop_exp(5'd2, 32'(i));
    chk("ovf_drain_empty", 32'(Empty), 32'd1);
    chk("ovf_sticky", 32'(Overflow), 32'd1);

    // Push and pop together while full
    do_reset();
    for (int i = 1; i <= 16; i++) tick(1'b1, 5'd2, 32'(i), 1'b0);
    tick(1'b1, 5'd2, 32'hAA, 1'b1);
    chk("fullpp_vld", 32'(RdValid), 32'd1);
    chk("fullpp_dat", RdData, 32'd1);
    chk("fullpp_count", 32'(Count), 32'd16);
    chk("fullpp_ovf", 32'(Overflow), 32'd0);
    for (int i = 2; i <= 16; i++) pop_exp(5'd2, 32'(i));
    pop_exp(5'd2, 32'hAA);
    chk("fullpp_empty", 32'(Empty), 32'd1);

    // Push and pop together while empty: pop ignored, no bypass
    tick(1'b1, 5'd3, 32'h77, 1'b1);
    chk("emptypp_vld", 32'(RdValid), 32'd0);
    chk("emptypp_count", 32'(Count), 32'd1);
    pop_exp(5'd3, 32'h77);

    // Halt on a j . loop with alternating fetch
    do_reset();
    pc_tick(32'h40);
    pc_tick(32'h44);
    pc_tick(32'h48);
    for (int i = 0; i < 8; i++) begin
      pc_tick((i % 2 == 0) ? 32'h4C : 32'h48);
      if (i == 6) chk("loop_not_yet", 32'(Halted), 32'd0);
    end
    chk("loop_halted", 32'(Halted), 32'd1);
    chk("loop_haltpc", HaltPC, 32'h48);
    PCResult = 32'h200;
    tick(1'b1, 5'd3, 32'h99, 1'b0);
    chk("late_count", 32'(Count), 32'd1);
    chk("late_sticky", 32'(Halted), 32'd1);
    pop_exp(5'd3, 32'h99);

    // Short park then a full park elsewhere
    do_reset();
    for (int i = 0; i < 5; i++) pc_tick(32'h20);
    chk("short_park", 32'(Halted), 32'd0);
    pc_tick(32'h30);
    for (int i = 0; i < 8; i++) begin
      pc_tick(32'h30);
      if (i == 6) chk("park_not_yet", 32'(Halted), 32'd0);
    end
    chk("park_halted", 32'(Halted), 32'd1);
    chk("park_haltpc", HaltPC, 32'h30);

    // Reset during pop with FIFO holding 5 and FSM in SETTLE
    do_reset();
    PCResult = 32'h500;
    for (int i = 1; i <= 5; i++) tick(1'b1, 5'd3, 32'(i), 1'b0);
    chk("pre_count", 32'(Count), 32'd5);
    chk("pre_state", 32'(dut.halt_state), 32'(SETTLE));
    Reset = 1'b1; RdEn = 1'b1; WBregwrite = 1'b1; WriteRegister = 5'd2; WriteData = 32'hEE;
    step();
    Reset = 1'b0; RdEn = 1'b0; WBregwrite = 1'b0;
    chk("mid_rst_count", 32'(Count), 32'd0);
    chk("mid_rst_rdvld", 32'(RdValid), 32'd0);
    chk("mid_rst_halted", 32'(Halted), 32'd0);
    chk("mid_rst_wcnt", WriteCount, 32'd0);
    chk("mid_rst_state", 32'(dut.halt_state), 32'(RUN));
    chk("mid_rst_empty", 32'(Empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
